mandel_solver: RTL and testbench

// Multi-limb fixed-point Mandelbrot escape-time engine for one pixel. A tile controller loads
// c (real/imag limbs), precision (limb count) and iteration limit, pulses start, waits for
// out_ready, then reads the escape count. One instance per tile pipeline.

---
 rtl/mandel_solver_if.sv | 30 +++
 rtl/mandel_solver.sv | 206 ++++++++++++++++++++
 tb/tb_mandel_solver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mandel_solver_if.sv
// Tile-controller <-> solver port bundle: configuration writes, start, and the held result.
interface mandel_solver_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27
);
    logic                       wr_real_en;
    logic                       wr_imag_en;
    logic [LIMB_INDEX_BITS-1:0] wr_index;
    logic [LIMB_SIZE_BITS-1:0]  real_data;
    logic [LIMB_SIZE_BITS-1:0]  imag_data;
    logic                       wr_num_limbs_en;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
    logic                       wr_iter_lim_en;
    logic [15:0]                iter_lim_data;
    logic                       start;
    logic                       out_ready;
    logic [15:0]                iterations;

    modport master (
        output wr_real_en, wr_imag_en, wr_index, real_data, imag_data,
        output wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
        input  out_ready, iterations
    );

    modport slave (
        input  wr_real_en, wr_imag_en, wr_index, real_data, imag_data,
        input  wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
        output out_ready, iterations
    );
endinterface

// File: rtl/mandel_solver.sv
// Multi-limb fixed-point Mandelbrot escape-time engine. Numbers are held left-aligned in a
// full-depth vector (limb 0 at the top); the three products use a shared limb/bit-serial pass.
module mandel_solver #(
    parameter int LIMB_INDEX_BITS   = 6,
    parameter int LIMB_SIZE_BITS    = 27,
    parameter int DIVERGENCE_RADIUS = 4
) (
    input  logic          clock,
    input  logic          reset,
    mandel_solver_if.slave bus
);
    localparam int NL  = 1 << LIMB_INDEX_BITS;
    localparam int W   = NL * LIMB_SIZE_BITS;
    localparam int AW  = W + 8;
    localparam int BCW = $clog2(LIMB_SIZE_BITS);
    localparam logic [BCW-1:0] BC_LAST = BCW'(LIMB_SIZE_BITS - 1);
    localparam logic [LIMB_INDEX_BITS-1:0] ONE_LIMB = {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};
    localparam logic signed [AW:0] RADIUS_C = $signed((AW+1)'(DIVERGENCE_RADIUS)) <<< (W - 4);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_UPDATE, S_MUL, S_DONE} state_e;

    // One serial step: add (or subtract, for the sign bit) the multiplicand, then halve with floor.
    function automatic logic [AW-1:0] mac_step(input logic [AW-1:0] acc, input logic [AW-1:0] mc,
                                               input logic bit_v, input logic neg);
        logic [AW-1:0] s;
        if (!bit_v) begin
            s = acc;
        end else if (neg) begin
            s = acc - mc;
        end else begin
            s = acc + mc;
        end
        return {s[AW-1], s[AW-1:1]};
    endfunction

    logic [LIMB_SIZE_BITS-1:0]  cr_mem_q [NL];
    logic [LIMB_SIZE_BITS-1:0]  ci_mem_q [NL];
    logic [LIMB_INDEX_BITS-1:0] num_limbs_q, n_eff_s, lc_q, lc_d;
    logic [15:0]                iter_lim_q, n_q, n_d, iter_q, iter_d;
    logic [BCW-1:0]             bc_q, bc_d;
    state_e                     state_q, state_d;
    logic                       ready_q, ready_d, cfg_we_s;
    logic [W-1:0]               zr_q, zr_d, zi_q, zi_d, cr_vec_s, ci_vec_s, lmask_s;
    logic [AW-1:0]              sqr_q, sqr_d, sqi_q, sqi_d, sqx_q, sqx_d, pmask_s;
    logic [AW-1:0]              mc_r_s, mc_i_s, mc_x_s, step_r_s, step_i_s, step_x_s;
    logic [AW:0]                mag_s;
    logic [LIMB_SIZE_BITS-1:0]  zr_limb_s, zi_limb_s;
    logic                       br_s, bi_s, last_bit_s, cross_ovf_s;

    assign cfg_we_s = reset && (state_q != S_CHECK) && (state_q != S_UPDATE) && (state_q != S_MUL);
    assign n_eff_s  = (num_limbs_q == '0) ? ONE_LIMB : num_limbs_q;

    // Limb storage has no reset; it only matters once written.
    always_ff @(posedge clock) begin
        if (cfg_we_s && bus.wr_real_en) cr_mem_q[bus.wr_index] <= bus.real_data;
        if (cfg_we_s && bus.wr_imag_en) ci_mem_q[bus.wr_index] <= bus.imag_data;
    end

    // Precision and iteration limit, writable only outside a solve.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_limbs_q <= ONE_LIMB;
            iter_lim_q  <= 16'd0;
        end else begin
            if (cfg_we_s && bus.wr_num_limbs_en) num_limbs_q <= bus.num_limbs_data;
            if (cfg_we_s && bus.wr_iter_lim_en)  iter_lim_q  <= bus.iter_lim_data;
        end
    end

    // Assemble c and the truncation mask from the active limbs only.
    always_comb begin
        cr_vec_s = '0;
        ci_vec_s = '0;
        lmask_s  = '0;
        for (int i = 0; i < NL; i++) begin
            if (i < int'(n_eff_s)) begin
                cr_vec_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS] = cr_mem_q[i];
                ci_vec_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS] = ci_mem_q[i];
                lmask_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS]  = {LIMB_SIZE_BITS{1'b1}};
            end else begin
                cr_vec_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS] = '0;
                ci_vec_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS] = '0;
                lmask_s[W-1-i*LIMB_SIZE_BITS -: LIMB_SIZE_BITS]  = '0;
            end
        end
    end

    assign pmask_s    = {8'hFF, lmask_s};
    assign zr_limb_s  = zr_q[W-1-int'(lc_q)*LIMB_SIZE_BITS -: LIMB_SIZE_BITS];
    assign zi_limb_s  = zi_q[W-1-int'(lc_q)*LIMB_SIZE_BITS -: LIMB_SIZE_BITS];
    assign br_s       = zr_limb_s[bc_q];
    assign bi_s       = zi_limb_s[bc_q];
    assign last_bit_s = (lc_q == '0) && (bc_q == BC_LAST);
    // Extra 4 fraction bits on the multiplicand rescale the product back to z's binary point.
    assign mc_r_s     = {{8{zr_q[W-1]}}, zr_q} << 3'd4;
    assign mc_i_s     = {{8{zi_q[W-1]}}, zi_q} << 3'd4;
    assign mc_x_s     = {{8{zr_q[W-1]}}, zr_q} << 3'd5;
    assign step_r_s   = mac_step(sqr_q, mc_r_s, br_s, last_bit_s);
    assign step_i_s   = mac_step(sqi_q, mc_i_s, bi_s, last_bit_s);
    assign step_x_s   = mac_step(sqx_q, mc_x_s, bi_s, last_bit_s);
    assign mag_s      = {sqr_q[AW-1], sqr_q} + {sqi_q[AW-1], sqi_q};
    // A cross term outside z's range implies |z|^2 > radius already; treat it as an escape.
    assign cross_ovf_s = !((&sqx_q[AW-1:W-1]) || !(|sqx_q[AW-1:W-1]));

    // Next-state and datapath update; start wins from any state.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        sqr_d   = sqr_q;
        sqi_d   = sqi_q;
        sqx_d   = sqx_q;
        lc_d    = lc_q;
        bc_d    = bc_q;
        ready_d = ready_q;
        iter_d  = iter_q;
        if (bus.start) begin
            state_d = S_CHECK;
            n_d     = 16'd0;
            zr_d    = '0;
            zi_d    = '0;
            sqr_d   = '0;
            sqi_d   = '0;
            sqx_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (($signed(mag_s) > RADIUS_C) || cross_ovf_s || (n_q == iter_lim_q)) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        iter_d  = n_q;
                    end else begin
                        state_d = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    zr_d    = sqr_q[W-1:0] - sqi_q[W-1:0] + cr_vec_s;
                    zi_d    = sqx_q[W-1:0] + ci_vec_s;
                    n_d     = n_q + 16'd1;
                    sqr_d   = '0;
                    sqi_d   = '0;
                    sqx_d   = '0;
                    lc_d    = n_eff_s - ONE_LIMB;
                    bc_d    = '0;
                    state_d = S_MUL;
                end
                S_MUL: begin
                    if (last_bit_s) begin
                        sqr_d   = step_r_s & pmask_s;
                        sqi_d   = step_i_s & pmask_s;
                        sqx_d   = step_x_s & pmask_s;
                        state_d = S_CHECK;
                    end else if (bc_q == BC_LAST) begin
                        sqr_d = step_r_s;
                        sqi_d = step_i_s;
                        sqx_d = step_x_s;
                        bc_d  = '0;
                        lc_d  = lc_q - ONE_LIMB;
                    end else begin
                        sqr_d = step_r_s;
                        sqi_d = step_i_s;
                        sqx_d = step_x_s;
                        bc_d  = bc_q + BCW'(1);
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Solver state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= 16'd0;
            zr_q    <= '0;
            zi_q    <= '0;
            sqr_q   <= '0;
            sqi_q   <= '0;
            sqx_q   <= '0;
            lc_q    <= '0;
            bc_q    <= '0;
            ready_q <= 1'b0;
            iter_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            sqr_q   <= sqr_d;
            sqi_q   <= sqi_d;
            sqx_q   <= sqx_d;
            lc_q    <= lc_d;
            bc_q    <= bc_d;
            ready_q <= ready_d;
            iter_q  <= iter_d;
        end
    end

    assign bus.out_ready  = ready_q;
    assign bus.iterations = iter_q;
endmodule

// File: tb/tb_mandel_solver.sv
// Directed bench for mandel_solver: escape counts from a real-valued reference orbit, plus
// start/restart/reset/busy-write behaviour.
module tb_mandel_solver;
    localparam int LIB = 6;
    localparam int LSB = 27;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   exp_iter = 0;

    always #5 clock = ~clock;

    mandel_solver_if #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB)) bus_if ();

    mandel_solver #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB), .DIVERGENCE_RADIUS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Escape time straight from the definition, in real arithmetic.
    function automatic int model_iters(input real cr, input real ci, input int lim);
        real zr = 0.0, zi = 0.0, t;
        for (int n = 0; n <= lim; n++) begin
            if (zr * zr + zi * zi > 4.0) return n;
            if (n == lim) return n;
            t  = zr * zr - zi * zi + cr;
            zi = 2.0 * zr * zi + ci;
            zr = t;
        end
        return lim;
    endfunction

    // Limb k of v: limb 0 carries sign + 3 integer bits + 23 fraction bits.
    function automatic logic [LSB-1:0] limb_val(input real v, input int k);
        real s;
        s = v * 8388608.0;
        for (int i = 0; i < k; i++) s = (s - $floor(s)) * 134217728.0;
        return LSB'(longint'($floor(s)));
    endfunction

    // Held result is compared on every cycle it is valid.
    always @(negedge clock) begin
        if (chk_en && reset && bus_if.out_ready) check("held_iters", int'(bus_if.iterations), exp_iter);
    end

    task automatic setup(input real cr, input real ci, input int nl, input int lim);
        int ne;
        ne = (nl == 0) ? 1 : nl;
        bus_if.wr_num_limbs_en = 1'b1;
        bus_if.num_limbs_data  = LIB'(nl);
        bus_if.wr_iter_lim_en  = 1'b1;
        bus_if.iter_lim_data   = 16'(lim);
        @(posedge clock); #1;
        bus_if.wr_num_limbs_en = 1'b0;
        bus_if.wr_iter_lim_en  = 1'b0;
        for (int k = 0; k <= ne; k++) begin
            bus_if.wr_real_en = 1'b1;
            bus_if.wr_imag_en = 1'b1;
            bus_if.wr_index   = LIB'(k);
            // One limb past the precision gets junk that must be ignored.
            bus_if.real_data  = (k == ne) ? {LSB{1'b1}} : limb_val(cr, k);
            bus_if.imag_data  = (k == ne) ? {LSB{1'b1}} : limb_val(ci, k);
            @(posedge clock); #1;
        end
        bus_if.wr_real_en = 1'b0;
        bus_if.wr_imag_en = 1'b0;
    endtask

    // mode 0: plain; 1: config writes while busy; 2: second start mid-solve.
    task automatic go(input string name, input int expv, input int nl, input int lim, input int mode);
        int ne, budget;
        bit seen;
        ne = (nl == 0) ? 1 : nl;
        budget = 64 * lim * ne * ne + 64;
        chk_en = 1'b0;
        exp_iter = expv;
        bus_if.start = 1'b1;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        check({name, "_ready_low"}, int'(bus_if.out_ready), 0);
        chk_en = 1'b1;
        if (mode == 1) begin
            repeat (5) @(posedge clock);
            #1;
            bus_if.wr_real_en = 1'b1; bus_if.wr_index = 6'd0; bus_if.real_data = 27'd0;
            bus_if.wr_iter_lim_en = 1'b1; bus_if.iter_lim_data = 16'd20;
            bus_if.wr_num_limbs_en = 1'b1; bus_if.num_limbs_data = 6'd1;
            @(posedge clock); #1;
            bus_if.wr_real_en = 1'b0; bus_if.wr_iter_lim_en = 1'b0; bus_if.wr_num_limbs_en = 1'b0;
        end
        if (mode == 2) begin
            repeat (40) @(posedge clock);
            #1;
            bus_if.start = 1'b1;
            @(posedge clock); #1;
            bus_if.start = 1'b0;
            check({name, "_ready_low_restart"}, int'(bus_if.out_ready), 0);
        end
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus_if.out_ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: out_ready still 0 after %0d cycles, required within budget", name, budget);
        end else begin
            check({name, "_iters"}, int'(bus_if.iterations), expv);
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic run(input string name, input real cr, input real ci, input int nl, input int lim,
                       input int hand);
        int expv;
        setup(cr, ci, nl, lim);
        expv = model_iters(cr, ci, lim);
        check({name, "_model"}, expv, hand);
        go(name, expv, nl, lim, 0);
    endtask

    initial begin
        bus_if.wr_real_en = 1'b0; bus_if.wr_imag_en = 1'b0; bus_if.wr_index = '0;
        bus_if.real_data = '0; bus_if.imag_data = '0;
        bus_if.wr_num_limbs_en = 1'b0; bus_if.num_limbs_data = '0;
        bus_if.wr_iter_lim_en = 1'b0; bus_if.iter_lim_data = '0;
        bus_if.start = 1'b0;
        #1 reset = 1'b0;
        #11;
        check("reset_ready", int'(bus_if.out_ready), 0);
        check("reset_iters", int'(bus_if.iterations), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        check("limb_of_one", int'(limb_val(1.0, 0)), 'h0800000);
        check("limb_of_m2", int'(limb_val(-2.0, 0)), 'h7000000);

        go("reset_defaults", 0, 1, 0, 0);
        run("c_zero",  0.0,  0.0, 3, 5, 5);
        run("c_one",   1.0,  0.0, 3, 5, 3);
        run("c_two",   2.0,  0.0, 3, 5, 2);
        run("c_three", 3.0,  0.0, 3, 5, 1);
        run("c_m2",   -2.0,  0.0, 3, 5, 5);
        run("c_i",     0.0,  1.0, 3, 20, 20);
        run("lim0",    1.0,  0.0, 3, 0, 0);
        run("n0",      1.0,  0.0, 0, 5, 3);
        run("n1",      1.5,  0.0, 1, 6, 2);
        run("frac",    0.25, 0.5, 2, 4, 4);
        run("wide",   -1.0,  0.0, 63, 3, 3);

        setup(1.0, 0.0, 3, 5);
        go("busy_writes", 3, 3, 5, 1);
        go("busy_kept", 3, 3, 5, 0);

        setup(0.0, 0.0, 3, 20);
        go("restart", 20, 3, 20, 2);

        setup(0.0, 0.0, 3, 20);
        chk_en = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
        #2;
        check("midreset_ready", int'(bus_if.out_ready), 0);
        check("midreset_iters", int'(bus_if.iterations), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        go("post_reset_defaults", 0, 1, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
